c_rr_lock_arbiter: RTL
======================

// Module: c_rr_lock_arbiter
// PURPOSE
//  Round-robin arbiter with packet lock for shared resources (switch/VC allocation).
//  Grant selection is a wraparound parallel-prefix search over requests, starting at the
//  priority pointer. Priority advances only when a transfer completes (ack & tail).
//  A multi-cycle packet holds its grant from first ack until tail.
// PARAMETERS
//  num_ports  4  number of requesters (>=1; need not be a power of two)
//  idx_width  clogb(num_ports), min 1  width of gnt_idx and owner (localparam)
// PORTS
//  clk      input   1          clock
//  reset    input   1          asynchronous, active-low reset
//  req      input   num_ports  [0:num_ports-1] request per port; port 0 leftmost
//  ack      input   1          current grant consumed this cycle (one flit transferred)
//  tail     input   1          qualifies ack: consumed flit is the last of its packet
//  gnt      output  num_ports  [0:num_ports-1] one-hot grant, combinational
//  gnt_val  output  1          |gnt
//  gnt_idx  output  idx_width  binary index of granted port; 0 when gnt_val=0
//  locked   output  1          1 while FSM is in LOCKED
// BEHAVIOUR
//  State
//  - prio: one-hot [0:num_ports-1], highest-priority port.
//  - owner: idx_width, the locked port.
//  - FSM: IDLE | LOCKED.
//  Reset (reset=0, asynchronous)
//  - prio=port 0, owner=0, FSM=IDLE.
//  - gnt, gnt_val, gnt_idx and locked are forced to 0 while reset is asserted,
//    regardless of req.
//  Grant in IDLE (zero latency)
//  - gnt[i]=1 iff req[i]=1 and no requesting port lies in circular order
//    prio, prio+1, ..., i-1 (mod num_ports).
//  - Computed as a wraparound prefix-OR over req, seeded at prio.
//  - req=0 gives gnt=0 and gnt_val=0.
//  Grant in LOCKED
//  - gnt = onehot(owner) & req[owner]; other requests are ignored.
//  Transitions, evaluated at posedge clk, only when gnt_val=1 and ack=1
//  - IDLE, ack & ~tail: go to LOCKED, owner <= gnt_idx, prio unchanged.
//  - IDLE, ack & tail: stay IDLE, prio <= port (gnt_idx+1) mod num_ports.
//  - LOCKED, ack & ~tail: stay LOCKED.
//  - LOCKED, ack & tail: go to IDLE, prio <= port (owner+1) mod num_ports.
//  - ack while gnt_val=0: ignored; no state change.
//  - gnt_val=1 and ack=0: no state change; the same grant is re-presented next cycle
//    if req is unchanged.
//  Boundaries
//  - Pointer wraps: after port num_ports-1 wins, prio = port 0.
//  - A requester may not drop req while it owns the lock. If it does, gnt=0 and the FSM
//    stays LOCKED; a simulation assertion flags it.
//  - num_ports=1: gnt=req, prio is constant, the lock FSM is still active.
//  - Reset asserted in LOCKED: grant drops immediately. After release the FSM is IDLE
//    and prio=port 0.
//  - Invariants: gnt is one-hot or zero; gnt is a subset of req; locked=1 implies
//    gnt is a subset of onehot(owner).
// TESTING (num_ports=4, vectors are [0:3])
//  1 Reset release, req=1111, ack=0: gnt=1000, gnt_idx=0; holds 1000 for several cycles.
//  2 req=1111, ack=tail=1 every cycle: gnt_idx sequence 0,1,2,3,0,1 (rotation and wrap).
//  3 After port 2 wins with tail (prio=port 3), req=1100: gnt=1000 (wraparound search).
//  4 Port 1 wins with ack, tail=0; port 0 then also requests; 3 more acks with tail=0,
//    then ack&tail: gnt=0100 with locked=1 throughout; next cycle with req=1010,
//    gnt=0010 and locked=0.
//  5 Async reset pulse mid-cycle while LOCKED on port 3: gnt=0000 immediately;
//    after release with req=0001, gnt=0001 and locked=0.
//  6 Random req/ack/tail for 10k cycles: invariants hold; no port waits more than
//    num_ports completed packets while continuously requesting.

Source files
------------

// File: rtl/c_rr_lock_arbiter.sv
// Round-robin arbiter with packet lock: a wraparound prefix search from the priority
// pointer picks a winner, and a multi-flit packet keeps its grant from first ack to tail.
module c_rr_lock_arbiter #(
  parameter  int num_ports = 4,
  localparam int idx_width = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:num_ports-1] req,
  input  logic                 ack,
  input  logic                 tail,
  output logic [0:num_ports-1] gnt,
  output logic                 gnt_val,
  output logic [idx_width-1:0] gnt_idx,
  output logic                 locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  function automatic logic [0:num_ports-1] to_onehot(input logic [idx_width-1:0] idx);
    logic [0:num_ports-1] v;
    v = '0;
    for (int i = 0; i < num_ports; i++)
      if (idx == idx_width'(i)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [idx_width-1:0] next_port(input logic [idx_width-1:0] idx);
    return (idx == idx_width'(num_ports - 1)) ? '0 : idx + idx_width'(1);
  endfunction

  state_t               state_q, state_d;
  logic [0:num_ports-1] prio_q, prio_d;
  logic [idx_width-1:0] owner_q, owner_d;
  logic [0:num_ports-1] search_gnt;
  logic [0:num_ports-1] lock_gnt;

  // Two passes over req: the first pass arms at prio, the second wraps around to the
  // ports below it. 'seen' is the running prefix-OR of requests since the seed.
  always_comb begin : prefix_search
    logic seen;
    logic started;
    // NOTE: blocking assignments here build a ripple chain within one evaluation; every
    // variable gets a value before the loop so no latch can be inferred.
    search_gnt = '0;
    seen       = 1'b0;
    started    = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < num_ports; i++) begin
        started = started | prio_q[i];
        if (started && req[i] && !seen) search_gnt[i] = 1'b1;
        seen = seen | (started & req[i]);
      end
    end
  end

  assign lock_gnt = to_onehot(owner_q) & req;

  // Outputs are gated by reset so nothing is granted while reset is held.
  assign gnt     = !reset ? '0 : ((state_q == LOCKED) ? lock_gnt : search_gnt);
  assign gnt_val = |gnt;
  assign locked  = reset && (state_q == LOCKED);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < num_ports; i++)
      if (gnt[i]) gnt_idx = gnt_idx | idx_width'(i);
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    if (gnt_val && ack) begin
      case (state_q)
        IDLE: begin
          if (tail) begin
            prio_d = to_onehot(next_port(gnt_idx));
          end else begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (tail) begin
            state_d = IDLE;
            prio_d  = to_onehot(next_port(owner_q));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= to_onehot('0);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  // The lock owner must keep requesting until its tail flit is consumed.
  a_owner_holds_req : assert property (
    @(posedge clk) disable iff (!reset)
    (state_q == LOCKED) |-> |(req & to_onehot(owner_q))
  ) else $error("lock owner dropped its request while LOCKED");

endmodule
